// File: rtl/morse_key_decoder_if.sv
// Signal bundle between a Morse key front end and its consumer.
// master : drives the raw key and the speed select, receives decoded characters.
// slave  : the decoder side; it samples key_in/speed_adjust and drives the
//          character, word-gap and busy outputs.
interface morse_key_decoder_if;
  logic       key_in;
  logic       speed_adjust;
  logic       char_valid;
  logic [5:0] char_code;
  logic [2:0] sym_len;
  logic [4:0] sym_bits;
  logic       word_gap;
  logic       busy;

  modport master (
    output key_in, speed_adjust,
    input  char_valid, char_code, sym_len, sym_bits, word_gap, busy
  );

  modport slave (
    input  key_in, speed_adjust,
    output char_valid, char_code, sym_len, sym_bits, word_gap, busy
  );
endinterface

// File: rtl/morse_key_decoder.sv
// Hand-keyed Morse receiver: synchronises and debounces a push-button, times
// marks and spaces in dot units, classifies dots/dashes, detects character and
// word gaps and translates the assembled pattern with the ITU table.
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   kif  - slave modport: key_in, speed_adjust in; char_valid, char_code,
//          sym_len, sym_bits, word_gap, busy out
// Parameters:
//   UNIT_CYCLES     - clk cycles per dot unit when speed_adjust = 1
//   DEBOUNCE_CYCLES - cycles a new key level must persist before acceptance
module morse_key_decoder #(
  parameter int unsigned UNIT_CYCLES     = 10_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  morse_key_decoder_if.slave kif
);

  localparam logic [31:0] DB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
  // Thresholds are compared against counters that start at 0 on the edge that
  // opens the interval, so each is one less than its length in cycles.
  localparam logic [31:0] DASH_FAST   = 32'(2 * UNIT_CYCLES - 1);
  localparam logic [31:0] CHAR_FAST   = 32'(3 * UNIT_CYCLES - 1);
  localparam logic [31:0] WORD_FAST   = 32'(7 * UNIT_CYCLES - 1);
  localparam logic [31:0] DASH_SLOW   = 32'(6 * UNIT_CYCLES - 1);
  localparam logic [31:0] CHAR_SLOW   = 32'(9 * UNIT_CYCLES - 1);
  localparam logic [31:0] WORD_SLOW   = 32'(21 * UNIT_CYCLES - 1);
  localparam logic [5:0]  CODE_INVALID = 6'd63;

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  // ITU table; pattern bits above len are always zero in the shift register.
  function automatic logic [5:0] itu_lookup(input logic [2:0] len,
                                            input logic [4:0] bits);
    logic [5:0] code;
    case ({len, bits})
      8'b010_00010: code = 6'd0;   // A .-
      8'b100_00001: code = 6'd1;   // B -...
      8'b100_00101: code = 6'd2;   // C -.-.
      8'b011_00001: code = 6'd3;   // D -..
      8'b001_00000: code = 6'd4;   // E .
      8'b100_00100: code = 6'd5;   // F ..-.
      8'b011_00011: code = 6'd6;   // G --.
      8'b100_00000: code = 6'd7;   // H ....
      8'b010_00000: code = 6'd8;   // I ..
      8'b100_01110: code = 6'd9;   // J .---
      8'b011_00101: code = 6'd10;  // K -.-
      8'b100_00010: code = 6'd11;  // L .-..
      8'b010_00011: code = 6'd12;  // M --
      8'b010_00001: code = 6'd13;  // N -.
      8'b011_00111: code = 6'd14;  // O ---
      8'b100_00110: code = 6'd15;  // P .--.
      8'b100_01011: code = 6'd16;  // Q --.-
      8'b011_00010: code = 6'd17;  // R .-.
      8'b011_00000: code = 6'd18;  // S ...
      8'b001_00001: code = 6'd19;  // T -
      8'b011_00100: code = 6'd20;  // U ..-
      8'b100_01000: code = 6'd21;  // V ...-
      8'b011_00110: code = 6'd22;  // W .--
      8'b100_01001: code = 6'd23;  // X -..-
      8'b100_01101: code = 6'd24;  // Y -.--
      8'b100_00011: code = 6'd25;  // Z --..
      8'b101_11111: code = 6'd26;  // 0 -----
      8'b101_11110: code = 6'd27;  // 1 .----
      8'b101_11100: code = 6'd28;  // 2 ..---
      8'b101_11000: code = 6'd29;  // 3 ...--
      8'b101_10000: code = 6'd30;  // 4 ....-
      8'b101_00000: code = 6'd31;  // 5 .....
      8'b101_00001: code = 6'd32;  // 6 -....
      8'b101_00011: code = 6'd33;  // 7 --...
      8'b101_00111: code = 6'd34;  // 8 ---..
      8'b101_01111: code = 6'd35;  // 9 ----.
      default:      code = CODE_INVALID;
    endcase
    return code;
  endfunction

  logic        sync_p0, sync_p1, key_db;
  logic [31:0] db_cnt;
  logic        db_accept, key_rise, key_fall;

  state_t      state;
  logic [31:0] mark_cnt, space_cnt;
  logic [4:0]  shreg;
  logic [2:0]  sym_cnt;
  logic        ovf, u_fast;
  logic [31:0] th_dash, th_char, th_word;

  logic        char_valid_r, word_gap_r, busy_r;
  logic [5:0]  char_code_r;
  logic [2:0]  sym_len_r;
  logic [4:0]  sym_bits_r;

  // The FSM reacts on the same edge that key_db changes, so mark and space
  // counters start exactly on the debounced transition.
  assign db_accept = (sync_p1 != key_db) && (db_cnt == DB_LAST);
  assign key_rise  = db_accept && sync_p1;
  assign key_fall  = db_accept && !sync_p1;

  always_comb begin
    th_dash = u_fast ? DASH_FAST : DASH_SLOW;
    th_char = u_fast ? CHAR_FAST : CHAR_SLOW;
    th_word = u_fast ? WORD_FAST : WORD_SLOW;
  end

  // ---- stage p0/p1: synchroniser, then debounce ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      key_db  <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync_p0 <= kif.key_in;
      sync_p1 <= sync_p0;
      if (sync_p1 == key_db) begin
        db_cnt <= '0;
      end else if (db_accept) begin
        key_db <= sync_p1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

  // ---- decode FSM on the debounced key ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      mark_cnt     <= '0;
      space_cnt    <= '0;
      shreg        <= '0;
      sym_cnt      <= '0;
      ovf          <= 1'b0;
      u_fast       <= 1'b1;
      char_valid_r <= 1'b0;
      word_gap_r   <= 1'b0;
      busy_r       <= 1'b0;
      char_code_r  <= CODE_INVALID;
      sym_len_r    <= '0;
      sym_bits_r   <= '0;
    end else begin
      char_valid_r <= 1'b0;
      word_gap_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (key_rise) begin
            state    <= MARK;
            mark_cnt <= '0;
            shreg    <= '0;
            sym_cnt  <= '0;
            ovf      <= 1'b0;
            u_fast   <= kif.speed_adjust;
            busy_r   <= 1'b1;
          end
        end
        MARK: begin
          if (mark_cnt != '1) mark_cnt <= mark_cnt + 32'd1;
          if (key_fall) begin
            // mark_cnt lags the high time by one cycle here, hence 2U-1.
            if (sym_cnt == 3'd5) begin
              ovf <= 1'b1;
            end else begin
              shreg[sym_cnt] <= (mark_cnt >= th_dash);
              sym_cnt        <= sym_cnt + 3'd1;
            end
            space_cnt <= '0;
            state     <= SPACE;
          end
        end
        SPACE: begin
          if (space_cnt == th_char) begin
            char_valid_r <= 1'b1;
            char_code_r  <= ovf ? CODE_INVALID : itu_lookup(sym_cnt, shreg);
            sym_len_r    <= sym_cnt;
            sym_bits_r   <= shreg;
            busy_r       <= 1'b0;
          end
          if (key_rise) begin
            state    <= MARK;
            mark_cnt <= '0;
            busy_r   <= 1'b1;
            // At or past the character gap the press opens a new character;
            // the emission above has already captured the old pattern.
            if (space_cnt >= th_char) begin
              shreg   <= '0;
              sym_cnt <= '0;
              ovf     <= 1'b0;
              u_fast  <= kif.speed_adjust;
            end
          end else if (space_cnt == th_word) begin
            word_gap_r <= 1'b1;
            state      <= IDLE;
          end else begin
            space_cnt <= space_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign kif.char_valid = char_valid_r;
  assign kif.char_code  = char_code_r;
  assign kif.sym_len    = sym_len_r;
  assign kif.sym_bits   = sym_bits_r;
  assign kif.word_gap   = word_gap_r;
  assign kif.busy       = busy_r;

endmodule
